// File: rtl/cpu_control_sequencer.sv
// rtl/cpu_control_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM for the CPU datapath
// Define PERF_COUNT_EN to build the retired-instruction counter; otherwise retired_count is tied to 0.
module cpu_control_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_write_enable,
  output logic        pc_enable,
  output logic        pc_jump_sel,
  output logic        busy,
  output logic        halted,
  output logic        mem_error,
  output logic [2:0]  state,
  output logic [31:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             is_hlt;
  logic             is_ls;
  logic             is_jmp;
  logic             timed_out;

  assign is_hlt = (opcode == 6'd0);
  assign is_ls  = (opcode >= 6'd24) && (opcode <= 6'd27);
  assign is_jmp = (opcode >= 6'd28);

  // A zero MEM_TIMEOUT means wait for mem_ready forever.
  assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_IDLE;
      wait_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state != cur_state)
        wait_cnt <= '0;
      else if ((cur_state == S_FETCH) || (cur_state == S_MEM))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:   if (start) nxt_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      nxt_state = S_DECODE;
        else if (timed_out) nxt_state = S_ERROR;
      end
      S_DECODE: nxt_state = is_hlt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (is_jmp)     nxt_state = S_FETCH;
        else if (is_ls) nxt_state = S_MEM;
        else            nxt_state = S_WB;
      end
      S_MEM: begin
        if (mem_ready)      nxt_state = opcode[0] ? S_FETCH : S_WB;
        else if (timed_out) nxt_state = S_ERROR;
      end
      S_WB:     nxt_state = S_FETCH;
      default:  nxt_state = cur_state;
    endcase
  end

  always_comb begin
    imem_req         = 1'b0;
    ir_load          = 1'b0;
    dmem_req         = 1'b0;
    dmem_we          = 1'b0;
    reg_write_enable = 1'b0;
    pc_enable        = 1'b0;
    pc_jump_sel      = 1'b0;
    case (cur_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = mem_ready;
      end
      S_EXEC: begin
        if (is_jmp) begin
          pc_enable   = 1'b1;
          pc_jump_sel = branch_taken;
        end
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = opcode[0];
        pc_enable = mem_ready & opcode[0];
      end
      S_WB: begin
        reg_write_enable = 1'b1;
        pc_enable        = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (cur_state != S_IDLE) && (cur_state != S_HALT) && (cur_state != S_ERROR);
  assign halted    = (cur_state == S_HALT);
  assign mem_error = (cur_state == S_ERROR);
  assign state     = cur_state;

`ifdef PERF_COUNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retired_q <= '0;
    else if (pc_enable)
      retired_q <= retired_q + 32'd1;
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb/tb_cpu_control_sequencer.sv - randomized scoreboard bench for cpu_control_sequencer
module tb_cpu_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        imem_req;
  logic        ir_load;
  logic        dmem_req;
  logic        dmem_we;
  logic        reg_write_enable;
  logic        pc_enable;
  logic        pc_jump_sel;
  logic        busy;
  logic        halted;
  logic        mem_error;
  logic [2:0]  state;
  logic [31:0] retired_count;

  cpu_control_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_write_enable(reg_write_enable), .pc_enable(pc_enable), .pc_jump_sel(pc_jump_sel),
    .busy(busy), .halted(halted), .mem_error(mem_error), .state(state),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit jsel;
    bit rwe;
    bit we;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  exp_t se;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   model_retired = 0;

  int   op, fw, mw, lat, fc, mc, budget, n, cls;
  bit   bt, done, abort;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: invariants every cycle, and a scoreboard pop on each retire strobe.
  always @(negedge clk) begin
    if (rst) begin
      model_retired = 0;
    end else begin
      check("one_mem_req", 32'(imem_req && dmem_req), 32'd0);
      check("rwe_vs_we", 32'(reg_write_enable && dmem_we), 32'd0);
      if (pc_enable) begin
        if (sb.size() == 0) begin
          check("unexpected_retire", 32'(pc_enable), 32'd0);
        end else begin
          me = sb.pop_front();
          check("retire_cycle", 32'(cyc), 32'(me.cyc));
          check("retire_jump_sel", 32'(pc_jump_sel), 32'(me.jsel));
          check("retire_reg_write", 32'(reg_write_enable), 32'(me.rwe));
          check("retire_dmem_we", 32'(dmem_we), 32'(me.we));
`ifdef PERF_COUNT_EN
          check("retired_count", retired_count, 32'(model_retired));
`else
          check("retired_count", retired_count, 32'd0);
`endif
        end
        model_retired++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 6'd0; branch_taken = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outputs", 32'({imem_req, ir_load, dmem_req, dmem_we, reg_write_enable,
                                pc_enable, pc_jump_sel, busy, halted, mem_error}), 32'd0);
    check("reset_retired", retired_count, 32'd0);
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("fetch_entry", 32'(state), 32'd1);
    check("fetch_imem_req", 32'(imem_req), 32'd1);

    // Asynchronous reset in the middle of a fetch cycle.
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_outputs", 32'({imem_req, ir_load, dmem_req, dmem_we, reg_write_enable,
                                    pc_enable, pc_jump_sel, busy, halted, mem_error}), 32'd0);
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_fetch", 32'(state), 32'd1);

    // Fetch timeout with mem_ready held low.
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("timeout_fetch_cycles", 32'(n), 32'd16);
    check("timeout_state", 32'(state), 32'd7);
    check("timeout_mem_error", 32'(mem_error), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    mem_ready = 1'b1; start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("error_sticky_state", 32'(state), 32'd7);
    check("error_sticky_flag", 32'(mem_error), 32'd1);
    start = 1'b0; mem_ready = 1'b0;

    // mem_ready on the timeout cycle wins; then a halt instruction.
    do_reset();
    opcode = 6'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("late_ready_still_fetch", 32'(imem_req), 32'd1);
    mem_ready = 1'b1;
    #1;
    check("late_ready_ir_load", 32'(ir_load), 32'd1);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("late_ready_decode", 32'(state), 32'd2);
    check("late_ready_no_error", 32'(mem_error), 32'd0);
    @(posedge clk); #1;
    check("halt_state", 32'(state), 32'd6);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_busy", 32'(busy), 32'd0);
    start = 1'b1; mem_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("halt_sticky", 32'(state), 32'd6);
    check("halt_no_pc", 32'(pc_enable), 32'd0);
    start = 1'b0; mem_ready = 1'b0;

    // Randomized instruction stream against the latency/strobe model.
    do_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 250 && !abort; i++) begin
      cls = $urandom_range(0, 2);
      if (cls == 0)      op = $urandom_range(1, 23);
      else if (cls == 1) op = $urandom_range(24, 27);
      else               op = $urandom_range(28, 63);
      bt = 1'($urandom_range(0, 1));
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      se.jsel = 1'b0; se.rwe = 1'b0; se.we = 1'b0;
      if (op >= 28) begin
        lat = fw + 3;
        se.jsel = bt;
      end else if (op >= 24) begin
        if (op % 2 == 1) begin
          lat = fw + mw + 4;
          se.we = 1'b1;
        end else begin
          lat = fw + mw + 5;
          se.rwe = 1'b1;
        end
      end else begin
        lat = fw + 4;
        se.rwe = 1'b1;
      end
      se.cyc = cyc + lat - 1;
      sb.push_back(se);

      opcode = 6'(op); branch_taken = bt;
      fc = 0; mc = 0; done = 1'b0; budget = 0;
      while (!done) begin
        if (imem_req) begin
          mem_ready = (fc >= fw);
          fc++;
        end else if (dmem_req) begin
          mem_ready = (mc >= mw);
          mc++;
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        if (pc_enable) done = 1'b1;
        budget++;
        if (!done && budget > 60) begin
          check("retire_timeout", 32'(budget), 32'd0);
          done = 1'b1;
          abort = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
Multi-cycle control FSM that sequences the CPU datapath through fetch, decode, execute, memory and write-back, driven by the 6-bit opcode held in the instruction register.
- Generates the IR load, PC advance/jump select, data-memory request/write and register-file write strobes.
- Sits beside the instruction interpreter, which supplies the field and mux decode. This block only decides *when* each strobe fires.
- Handles halt (opcode 0) and memory-handshake timeout.

Parameters:
- MEM_TIMEOUT, 15, maximum extra wait cycles for mem_ready in FETCH or MEM before entering ERROR; 0 disables the timeout.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin execution from IDLE
- opcode  input  6  instruction[31:26] from the instruction register
- branch_taken  input  1  ALU branch condition, valid in EXEC
- mem_ready  input  1  memory handshake completion, shared by I-mem and D-mem
- imem_req  output  1  instruction fetch request
- ir_load  output  1  latch fetched word into the instruction register
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write (store)
- reg_write_enable  output  1  register file write strobe
- pc_enable  output  1  PC update strobe
- pc_jump_sel  output  1  1 = load jump/branch target, 0 = PC+4; meaningful only while pc_enable=1
- busy  output  1  high in every state except IDLE, HALT and ERROR
- halted  output  1  high in HALT
- mem_error  output  1  high in ERROR
- state  output  3  current state encoding (debug)
- retired_count  output  32  retired instructions (see Optional Feature)

Behaviour:
- Clock, reset and timing:
  - Single clk domain.
  - rst is asynchronous and active-high: it forces state=IDLE, the wait counter to 0 and retired_count to 0.
  - All outputs are 0 in IDLE. This also applies when rst asserts mid-operation: the in-flight instruction is abandoned with no strobes.
  - State and wait counter are registered. Strobes are combinational from state, opcode and mem_ready.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.
- Opcode classes:
  - HLT: 0.
  - ALU: 1–15 (R-type) and 16–23 (immediate).
  - LS: 24–27; store when opcode[0]=1 (25, 27), load otherwise.
  - JMP: 28–63.
- IDLE: start=1 -> FETCH. start is ignored in all other states.
- FETCH: imem_req=1.
  - mem_ready=1 -> ir_load=1 in the same cycle, then go to DECODE.
  - Otherwise the counter increments.
  - counter==MEM_TIMEOUT with mem_ready=0 (MEM_TIMEOUT≠0) -> ERROR.
  - mem_ready arriving on the timeout cycle wins.
- DECODE: HLT -> HALT, PC not advanced. Otherwise -> EXEC.
- EXEC:
  - ALU -> WB.
  - LS -> MEM.
  - JMP: pc_enable=1, pc_jump_sel=branch_taken, instruction retires, -> FETCH.
- MEM: dmem_req=1, dmem_we=opcode[0]. Same wait/timeout rule as FETCH.
  - On mem_ready, store: pc_enable=1, retire, -> FETCH.
  - On mem_ready, load: -> WB.
- WB: reg_write_enable=1, pc_enable=1, pc_jump_sel=0, retire, -> FETCH.
- HALT and ERROR are sticky until rst. mem_ready is ignored there and in IDLE, DECODE, EXEC and WB.
- Wait counter: cleared on every entry to FETCH or MEM.
- Latency with mem_ready already high, cycles from entering FETCH to being back in FETCH:
  - ALU: 4.
  - Store: 4.
  - Load: 5.
  - JMP: 3.
- Invariants:
  - At most one of imem_req and dmem_req is high in any cycle.
  - reg_write_enable never coincides with dmem_we.

Optional Feature:
- Macro PERF_COUNT_EN.
- Defined: retired_count increments by 1 on every cycle with pc_enable=1. It wraps from 0xFFFFFFFF to 0 and is cleared by rst.
- Undefined: retired_count is tied to 0 and no counter register is built. All other behaviour is identical.

Test Plan:
- rst pulse mid-FETCH (imem_req=1) -> state=0 and all outputs 0 immediately, without waiting for a clk edge. Then start=1 -> FETCH on the next edge.
- opcode=3 (ALU), mem_ready tied 1 -> FETCH, DECODE, EXEC, WB over 4 cycles. ir_load in cycle 1; reg_write_enable and pc_enable in cycle 4; pc_jump_sel=0. With PERF_COUNT_EN, retired_count=1.
- opcode=24 (load), then opcode=25 (store), mem_ready delayed 2 cycles in MEM:
  - Load: dmem_req held 3 cycles with dmem_we=0, then WB.
  - Store: dmem_we=1, pc_enable on the mem_ready cycle, no reg_write_enable.
- opcode=30 with branch_taken=1 -> EXEC asserts pc_enable=1, pc_jump_sel=1, back to FETCH after 3 cycles.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> imem_req for 16 cycles, then state=7 and mem_error=1 sticky. Repeat with mem_ready=1 on the 16th cycle -> DECODE, no error.
- opcode=0 -> DECODE goes to HALT: halted=1, busy=0, no pc_enable; start and mem_ready are ignored until rst.
